// File: rtl/tdd_pkg.sv
// rtl/tdd_pkg.sv - shared width, state encoding and duplex-mode constants for the TDD frame controller
package tdd_pkg;

    localparam int CNT_W = 24;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdd_state_e;

    localparam logic FDD = 1'b0;
    localparam logic TDD = 1'b1;

endpackage

// File: rtl/tdd_window.sv
// rtl/tdd_window.sv - start/end window comparator with wrap-around handling
module tdd_window #(
    parameter int W = 24
) (
    input  logic [W-1:0] start_i,
    input  logic [W-1:0] end_i,
    input  logic [W-1:0] cnt_i,
    output logic         active_o
);

    // start<end is a plain range, start>end wraps past the frame end, start==end is empty
    always_comb begin
        active_o = 1'b0;
        if (start_i < end_i) begin
            active_o = (cnt_i >= start_i) && (cnt_i < end_i);
        end else if (start_i > end_i) begin
            active_o = (cnt_i >= start_i) || (cnt_i < end_i);
        end
    end

endmodule

// File: rtl/tdd_frame_ctrl.sv
// rtl/tdd_frame_ctrl.sv - TDD frame timing controller; frame counter built only with TDD_FRAME_NUM_EN
module tdd_frame_ctrl #(
    parameter int CNT_W = tdd_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    en,
    input  logic                    tddmode,
    input  logic [CNT_W-1:0]        frame_len,
    input  logic [CNT_W-1:0]        tstart,
    input  logic [CNT_W-1:0]        tend,
    input  logic [CNT_W-1:0]        rstart,
    input  logic [CNT_W-1:0]        rend,
    input  logic signed [CNT_W-1:0] frame_adj,
    input  logic                    adj_req,
    output logic                    adj_pending,
    output logic                    ien,
    output logic                    oen,
    output logic                    tx_rx,
    output logic                    sync,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [31:0]             frame_num
);

    import tdd_pkg::*;

    tdd_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] ts_q, ts_d;
    logic [CNT_W-1:0] te_q, te_d;
    logic [CNT_W-1:0] rs_q, rs_d;
    logic [CNT_W-1:0] re_q, re_d;
    logic [CNT_W-1:0] adj_q, adj_d;
    logic             pend_q, pend_d;
    logic             first_q, first_d;
    logic             new0_q, new0_d;
    logic             ien_q, ien_d;
    logic             oen_q, oen_d;
    logic             txrx_q, txrx_d;
    logic             sync_q, sync_d;

    logic                    run_go;
    logic                    start_load;
    logic                    wrap;
    logic                    load;
    logic                    tx_win;
    logic                    rx_win;
    logic [CNT_W-1:0]        eff_len;
    logic signed [CNT_W+1:0] len_sum;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state plus the run / frame-load strobes the datapath keys off
    always_comb begin
        state_d    = state_q;
        run_go     = 1'b0;
        start_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d    = RUN;
                    start_load = 1'b1;
                end
            end
            RUN: begin
                if (en) begin
                    run_go = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // first_q marks the pre-start slot after entering RUN: the first ce opens frame 0
    // without advancing, so every frame (including the first) spans cur_len ce strobes
    assign wrap = run_go && ce && !first_q &&
                  (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, len_q});
    assign load = start_load || wrap;

    // length for the frame being started: register value plus any pending adjustment,
    // clamped into 1 .. 2^CNT_W-1 so that lengths 0 and 1 both behave as a 1-sample frame
    always_comb begin
        len_sum = $signed({2'b00, frame_len});
        if (pend_q) begin
            len_sum = len_sum + $signed({{2{adj_q[CNT_W-1]}}, adj_q});
        end
        if (len_sum < $signed((CNT_W+2)'(1))) begin
            eff_len = CNT_W'(1);
        end else if (len_sum > $signed({2'b00, {CNT_W{1'b1}}})) begin
            eff_len = '1;
        end else begin
            eff_len = len_sum[CNT_W-1:0];
        end
    end

    tdd_window #(.W(CNT_W)) u_tx_win (
        .start_i  (ts_q),
        .end_i    (te_q),
        .cnt_i    (cnt_q),
        .active_o (tx_win)
    );

    tdd_window #(.W(CNT_W)) u_rx_win (
        .start_i  (rs_q),
        .end_i    (re_q),
        .cnt_i    (cnt_q),
        .active_o (rx_win)
    );

    // datapath next-state: shadows, adjustment, sample counter and registered outputs
    always_comb begin
        cnt_d   = cnt_q;
        len_d   = len_q;
        ts_d    = ts_q;
        te_d    = te_q;
        rs_d    = rs_q;
        re_d    = re_q;
        adj_d   = adj_q;
        pend_d  = pend_q;
        first_d = first_q;
        new0_d  = 1'b0;
        ien_d   = 1'b0;
        oen_d   = 1'b0;
        txrx_d  = 1'b0;
        sync_d  = 1'b0;

        // register writes only reach the counter at a frame boundary
        if (load) begin
            len_d = eff_len;
            ts_d  = tstart;
            te_d  = tend;
            rs_d  = rstart;
            re_d  = rend;
        end

        // a new request wins over the clear, so a request on a wrap lands one frame later
        if (adj_req) begin
            adj_d  = frame_adj;
            pend_d = 1'b1;
        end else if (load) begin
            pend_d = 1'b0;
        end

        if (start_load) begin
            cnt_d   = '0;
            first_d = 1'b1;
        end else if (!run_go) begin
            cnt_d   = '0;
            first_d = 1'b0;
        end else if (ce) begin
            first_d = 1'b0;
            new0_d  = first_q || wrap;
            cnt_d   = (first_q || wrap) ? '0 : cnt_q + CNT_W'(1);
        end

        // outputs lag frame_cnt by one clk; everything is forced low outside RUN
        if (run_go) begin
            sync_d = new0_q;
            if (tddmode == TDD) begin
                oen_d  = tx_win;
                txrx_d = tx_win;
                ien_d  = rx_win & ~tx_win;
            end else begin
                ien_d  = 1'b1;
                oen_d  = 1'b1;
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            len_q   <= '0;
            ts_q    <= '0;
            te_q    <= '0;
            rs_q    <= '0;
            re_q    <= '0;
            adj_q   <= '0;
            pend_q  <= 1'b0;
            first_q <= 1'b0;
            new0_q  <= 1'b0;
            ien_q   <= 1'b0;
            oen_q   <= 1'b0;
            txrx_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ts_q    <= ts_d;
            te_q    <= te_d;
            rs_q    <= rs_d;
            re_q    <= re_d;
            adj_q   <= adj_d;
            pend_q  <= pend_d;
            first_q <= first_d;
            new0_q  <= new0_d;
            ien_q   <= ien_d;
            oen_q   <= oen_d;
            txrx_q  <= txrx_d;
            sync_q  <= sync_d;
        end
    end

`ifdef TDD_FRAME_NUM_EN
    logic [31:0] fnum_q;

    // frame counter steps together with sync and is held at zero outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fnum_q <= '0;
        end else if (!run_go) begin
            fnum_q <= '0;
        end else if (new0_q) begin
            fnum_q <= fnum_q + 32'd1;
        end
    end

    assign frame_num = fnum_q;
`else
    assign frame_num = '0;
`endif

    assign frame_cnt   = cnt_q;
    assign adj_pending = pend_q;
    assign ien         = ien_q;
    assign oen         = oen_q;
    assign tx_rx       = txrx_q;
    assign sync        = sync_q;

endmodule

// File: tb/tb_tdd_frame_ctrl.sv
// tb/tb_tdd_frame_ctrl.sv - scoreboard bench for tdd_frame_ctrl
module tb_tdd_frame_ctrl;

    localparam int     W    = 24;
    localparam longint MAXL = (longint'(1) << W) - 1;
`ifdef TDD_FRAME_NUM_EN
    localparam int FN3 = 3;
`else
    localparam int FN3 = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, ce, en, tddmode, adj_req;
    logic [W-1:0]        frame_len, tstart, tend, rstart, rend;
    logic signed [W-1:0] frame_adj;
    logic                adj_pending, ien, oen, tx_rx, sync;
    logic [W-1:0]        frame_cnt;
    logic [31:0]         frame_num;

    tdd_frame_ctrl #(.CNT_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .en          (en),
        .tddmode     (tddmode),
        .frame_len   (frame_len),
        .tstart      (tstart),
        .tend        (tend),
        .rstart      (rstart),
        .rend        (rend),
        .frame_adj   (frame_adj),
        .adj_req     (adj_req),
        .adj_pending (adj_pending),
        .ien         (ien),
        .oen         (oen),
        .tx_rx       (tx_rx),
        .sync        (sync),
        .frame_cnt   (frame_cnt),
        .frame_num   (frame_num)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    bit           m_run, m_first, m_new0, m_pend;
    logic [W-1:0] m_cnt, m_len, m_ts, m_te, m_rs, m_re, m_adj;
    bit           e_ien, e_oen, e_txrx, e_sync;
    logic [31:0]  e_fnum;

    logic [63:0] exp_q[$];
    int          sync_t[$];
    int          clk_n = 0, ce_div = 1, ce_ph = 0, spec_mode = 0, width_err = 0, prev_cnt = 0, w0;
    bit          prev_sync = 0;

    function automatic bit in_win(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] c);
        if (s == e) return 1'b0;
        return (s < e) ? (c >= s && c < e) : !(c < s && c >= e);
    endfunction

    function automatic logic [63:0] cur_vec();
        return {3'b0, frame_num, frame_cnt, adj_pending, sync, tx_rx, oen, ien};
    endfunction

    function automatic logic [63:0] exp_vec();
        return {3'b0, e_fnum, m_cnt, m_pend, e_sync, e_txrx, e_oen, e_ien};
    endfunction

    function automatic int gap(input int i);
        if (sync_t.size() > i + 1) return sync_t[i+1] - sync_t[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_first = 0; m_new0 = 0; m_pend = 0;
        m_cnt = '0; m_len = '0; m_ts = '0; m_te = '0; m_rs = '0; m_re = '0; m_adj = '0;
        e_ien = 0; e_oen = 0; e_txrx = 0; e_sync = 0; e_fnum = '0;
    endtask

    // advance the model across one clock edge using the inputs currently driven
    task automatic model_step();
        bit     go, start, wrap, tw, rw, nw;
        longint len;
        go    = m_run && en;
        start = !m_run && en;
        wrap  = go && ce && !m_first && (longint'(m_cnt) + 1 >= longint'(m_len));
        if (go) begin
            tw = in_win(m_ts, m_te, m_cnt);
            rw = in_win(m_rs, m_re, m_cnt);
            if (tddmode) begin
                e_oen = tw; e_txrx = tw; e_ien = rw && !tw;
            end else begin
                e_ien = 1; e_oen = 1; e_txrx = 0;
            end
            e_sync = m_new0;
`ifdef TDD_FRAME_NUM_EN
            if (m_new0) e_fnum = e_fnum + 1;
`endif
        end else begin
            e_ien = 0; e_oen = 0; e_txrx = 0; e_sync = 0; e_fnum = '0;
        end
        nw = go && ce && (m_first || wrap);
        if (start || wrap) begin
            len = longint'(frame_len);
            if (m_pend) len = len + longint'($signed(m_adj));
            if (len < 1) len = 1;
            if (len > MAXL) len = MAXL;
            m_len = W'(len);
            m_ts = tstart; m_te = tend; m_rs = rstart; m_re = rend;
        end
        if (adj_req) begin
            m_adj = frame_adj; m_pend = 1;
        end else if (start || wrap) begin
            m_pend = 0;
        end
        if (!go) begin
            m_cnt = '0; m_first = start;
        end else if (ce) begin
            m_cnt   = (m_first || wrap) ? '0 : m_cnt + 1'b1;
            m_first = 0;
        end
        m_new0 = nw;
        m_run  = en;
    endtask

    task automatic tick();
        logic [2:0] w;
        int         p;
        if (ce_div <= 1) begin
            ce = 1'b1;
        end else begin
            ce    = (ce_ph == 0);
            ce_ph = (ce_ph + 1) % ce_div;
        end
        model_step();
        exp_q.push_back(exp_vec());
        @(posedge clk);
        #1;
        clk_n++;
        check_eq("cyc", cur_vec(), exp_q.pop_front());
        if (sync) begin
            sync_t.push_back(clk_n);
            if (prev_sync) width_err++;
        end
        prev_sync = sync;
        p = prev_cnt;
        w = 3'b000;
        case (spec_mode)
            1: w = {p < 4, p >= 5 && p <= 8, p >= 5 && p <= 8};
            2: w = {p >= 8 || p <= 1, 1'b0, 1'b0};
            4: w = {p <= 3, p >= 4 && p <= 7, p >= 4 && p <= 7};
            default: w = 3'b000;
        endcase
        if (spec_mode != 0) check_eq("win", 64'({ien, oen, tx_rx}), 64'(w));
        prev_cnt = int'(frame_cnt);
        adj_req  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_cnt(input int target, input int limit);
        for (int i = 0; i < limit && frame_cnt != W'(target); i++) tick();
        check_eq("reach_cnt", 64'(frame_cnt), 64'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 0; ce = 0; en = 0; tddmode = 0; adj_req = 0;
        frame_len = '0; tstart = '0; tend = '0; rstart = '0; rend = '0; frame_adj = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_state", cur_vec(), 64'd0);
        rst_n = 1;
        tick();

        // basic TDD windows, frame of 10
        frame_len = 24'd10; rstart = 24'd0; rend = 24'd4; tstart = 24'd5; tend = 24'd9;
        tddmode = 1; en = 1;
        sync_t.delete();
        tick();
        spec_mode = 1;
        ticks(35);
        check_eq("gapA", 64'(gap(0)), 64'd10);
        check_eq("gapA2", 64'(gap(1)), 64'd10);

        // one-shot adjustment of -3
        wait_cnt(3, 15);
        sync_t.delete();
        frame_adj = -24'sd3; adj_req = 1;
        tick();
        check_eq("adj_pend_set", 64'(adj_pending), 64'd1);
        spec_mode = 0;
        ticks(30);
        check_eq("adj_gap7", 64'(gap(0)), 64'd7);
        check_eq("adj_gap10", 64'(gap(1)), 64'd10);
        check_eq("adj_pend_clr", 64'(adj_pending), 64'd0);

        // wrap-around RX window, TX empty
        rstart = 24'd8; rend = 24'd2; tstart = 24'd0; tend = 24'd0;
        ticks(12);
        spec_mode = 2;
        ticks(20);
        // empty RX window
        spec_mode = 0; rstart = 24'd3; rend = 24'd3;
        ticks(12);
        spec_mode = 3;
        ticks(20);
        // overlapping windows, TX wins
        spec_mode = 0; rstart = 24'd0; rend = 24'd6; tstart = 24'd4; tend = 24'd8;
        ticks(12);
        spec_mode = 4;
        ticks(20);

        // ce every 4th clk
        spec_mode = 0; rstart = 24'd0; rend = 24'd4; tstart = 24'd5; tend = 24'd9;
        ce_div = 4; ce_ph = 0;
        ticks(60);
        sync_t.delete();
        width_err = 0;
        ticks(100);
        check_eq("gap_ce4", 64'(gap(0)), 64'd40);
        check_eq("sync_width", 64'(width_err), 64'd0);
        ce_div = 1;

        // mid-frame length write only affects the next frame
        ticks(12);
        wait_cnt(5, 25);
        frame_len = 24'd20; w0 = clk_n;
        sync_t.delete();
        ticks(30);
        check_eq("len_cur", (sync_t.size() > 0) ? 64'(sync_t[0] - w0) : 64'hdead, 64'd6);
        check_eq("len_next", 64'(gap(0)), 64'd20);

        // asynchronous reset mid-frame drops a pending adjustment
        frame_len = 24'd10; frame_adj = 24'sd5; adj_req = 1;
        tick();
        check_eq("pend_before_rst", 64'(adj_pending), 64'd1);
        ticks(3);
        #2 rst_n = 0;
        #1 check_eq("rst_async", cur_vec(), 64'd0);
        model_reset();
        prev_sync = 0; prev_cnt = 0;
        #2 rst_n = 1;
        sync_t.delete();
        ticks(25);
        check_eq("rst_gap", 64'(gap(0)), 64'd10);

        // FDD pass-through, idle, frame counter
        tddmode = 0;
        ticks(5);
        check_eq("fdd", 64'({ien, oen, tx_rx}), 64'b110);
        en = 0;
        tick();
        check_eq("idle_out", cur_vec(), 64'd0);
        tddmode = 1; en = 1;
        sync_t.delete();
        for (int i = 0; i < 60 && sync_t.size() < 3; i++) tick();
        check_eq("fnum3", 64'(frame_num), 64'(FN3));
        en = 0;
        tick();
        check_eq("fnum_idle", 64'(frame_num), 64'd0);

        // adjustment pending across IDLE clamps the first frame to 1
        frame_adj = -24'sd9; adj_req = 1; frame_len = 24'd5;
        tick();
        check_eq("pend_idle", 64'(adj_pending), 64'd1);
        en = 1;
        sync_t.delete();
        ticks(12);
        check_eq("clamp_gap1", 64'(gap(0)), 64'd1);
        check_eq("clamp_gap5", 64'(gap(1)), 64'd5);

        // zero frame length behaves as one sample
        frame_len = 24'd0;
        ticks(12);
        sync_t.delete();
        ticks(8);
        check_eq("len0_syncs", 64'(sync_t.size()), 64'd8);
        check_eq("len0_cnt", 64'(frame_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
